// File: rtl/otter_rfile_mp.sv
// Multi-ported register file with a hardwired-zero x0, two write ports, optional
// same-cycle write forwarding, and a one-register-per-cycle bulk clear sequencer.
module otter_rfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NRD*$clog2(NREGS)-1:0]      r_addr,
    output logic [NRD*XLEN-1:0]               r_data,
    input  logic [1:0]                        w_en,
    input  logic [$clog2(NREGS)-1:0]          w_addr0,
    input  logic [$clog2(NREGS)-1:0]          w_addr1,
    input  logic [XLEN-1:0]                   w_data0,
    input  logic [XLEN-1:0]                   w_data1,
    input  logic                              clear_req,
    output logic                              busy,
    output logic                              clear_done
);

    localparam int AW = $clog2(NREGS);
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;
    localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            clear_done_q, clear_done_d;

    always_comb begin
        regs_d       = regs_q;
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        clear_done_d = 1'b0;
        if (state_q == ST_IDLE) begin
            // Port 1 is applied last so it wins an address collision.
            if (w_en[0] && (w_addr0 != '0)) regs_d[w_addr0] = w_data0;
            if (w_en[1] && (w_addr1 != '0)) regs_d[w_addr1] = w_data1;
            if (clear_req) begin
                state_d   = ST_CLEAR;
                clr_ptr_d = AW'(1);
            end
        end else begin
            regs_d[clr_ptr_q] = '0;
            clr_ptr_d         = clr_ptr_q + AW'(1);
            if (clr_ptr_q == LAST_REG) begin
                state_d      = ST_IDLE;
                clr_ptr_d    = '0;
                clear_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q       <= '{default: '0};
            state_q      <= ST_IDLE;
            clr_ptr_q    <= '0;
            clear_done_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign busy       = (state_q == ST_CLEAR);
    assign clear_done = clear_done_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        assign ra = r_addr[k*AW +: AW];
        always_comb begin
            rd = (ra == '0) ? '0 : regs_q[ra];
            // Forwarding is suppressed during a clear since writes are dropped then.
            if ((BYPASS != 0) && (state_q == ST_IDLE) && (ra != '0)) begin
                if (w_en[1] && (w_addr1 == ra))      rd = w_data1;
                else if (w_en[0] && (w_addr0 == ra)) rd = w_data0;
            end
        end
        assign r_data[k*XLEN +: XLEN] = rd;
    end

endmodule

// File: tb/tb_otter_rfile_mp.sv
// Bench for otter_rfile_mp: two 32-bit instances (BYPASS=0/1) sharing inputs,
// plus a 64-bit/16-register/3-read-port instance.
module tb_otter_rfile_mp;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  r_addr = '0;
    logic [1:0]  w_en = '0;
    logic [4:0]  w_addr0 = '0, w_addr1 = '0;
    logic [31:0] w_data0 = '0, w_data1 = '0;
    logic        clear_req = 1'b0;
    logic [63:0] r_data_a, r_data_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic [11:0]  r_addr_c = '0;
    logic [1:0]   w_en_c = '0;
    logic [3:0]   w_addr0_c = '0, w_addr1_c = '0;
    logic [63:0]  w_data0_c = '0, w_data1_c = '0;
    logic         clear_req_c = 1'b0;
    logic [191:0] r_data_c;
    logic         busy_c, done_c;

    logic [31:0] model [32];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    otter_rfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_data(r_data_a), .w_en(w_en),
        .w_addr0(w_addr0), .w_addr1(w_addr1), .w_data0(w_data0), .w_data1(w_data1),
        .clear_req(clear_req), .busy(busy_a), .clear_done(done_a));

    otter_rfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_data(r_data_b), .w_en(w_en),
        .w_addr0(w_addr0), .w_addr1(w_addr1), .w_data0(w_data0), .w_data1(w_data1),
        .clear_req(clear_req), .busy(busy_b), .clear_done(done_b));

    otter_rfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .r_addr(r_addr_c), .r_data(r_data_c), .w_en(w_en_c),
        .w_addr0(w_addr0_c), .w_addr1(w_addr1_c), .w_data0(w_data0_c), .w_data1(w_data1_c),
        .clear_req(clear_req_c), .busy(busy_c), .clear_done(done_c));

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        @(negedge clk);
        w_en = en; w_addr0 = a0; w_data0 = d0; w_addr1 = a1; w_data1 = d1;
        @(negedge clk);
        w_en = 2'b00;
        if (en[0] && a0 != 5'd0) model[a0] = d0;
        if (en[1] && a1 != 5'd0) model[a1] = d1;
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (3) @(negedge clk);
        n_cmp += 3;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_a); end
        if (busy_c !== 1'b0) begin n_err++; $display("FAIL reset_busy_c: got %b want 0", busy_c); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0", busy_a); end
        if (done_a !== 1'b0) begin n_err++; $display("FAIL post_reset_done: got %b want 0", done_a); end
        for (int i = 0; i < 32; i++) sb.push_back('{addr: 5'(i), data: 64'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); r_addr = {e.addr, e.addr}; #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp += 2;
                if (r_data_a[k*32 +: 32] !== e.data[31:0]) begin n_err++;
                    $display("FAIL reset_read_a r%0d p%0d: got %h want %h", e.addr, k, r_data_a[k*32 +: 32], e.data[31:0]); end
                if (r_data_b[k*32 +: 32] !== e.data[31:0]) begin n_err++;
                    $display("FAIL reset_read_b r%0d p%0d: got %h want %h", e.addr, k, r_data_b[k*32 +: 32], e.data[31:0]); end
            end
        end
        for (int i = 0; i < 16; i++) sb.push_back('{addr: 5'(i), data: 64'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            r_addr_c = {3{e.addr[3:0]}}; #1;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (r_data_c[k*64 +: 64] !== e.data) begin n_err++;
                    $display("FAIL reset_read_c r%0d p%0d: got %h want %h", e.addr, k, r_data_c[k*64 +: 64], e.data); end
            end
        end
    endtask

    task automatic test_write_collision();
        exp_t e;
        wr(2'b11, 5'd7, 32'hAAAA_AAAA, 5'd7, 32'h5555_5555);
        sb.push_back('{addr: 5'd7, data: 64'h5555_5555});
        wr(2'b01, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'h0);
        sb.push_back('{addr: 5'd0, data: 64'h0});
        wr(2'b10, 5'd0, 32'h0, 5'd0, 32'hDEAD_BEEF);
        sb.push_back('{addr: 5'd0, data: 64'h0});
        wr(2'b11, 5'd3, 32'h0000_0033, 5'd4, 32'h0000_0044);
        sb.push_back('{addr: 5'd3, data: 64'h33});
        sb.push_back('{addr: 5'd4, data: 64'h44});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); r_addr = {e.addr, e.addr}; #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp += 2;
                if (r_data_a[k*32 +: 32] !== e.data[31:0]) begin n_err++;
                    $display("FAIL write_a r%0d p%0d: got %h want %h", e.addr, k, r_data_a[k*32 +: 32], e.data[31:0]); end
                if (r_data_b[k*32 +: 32] !== e.data[31:0]) begin n_err++;
                    $display("FAIL write_b r%0d p%0d: got %h want %h", e.addr, k, r_data_b[k*32 +: 32], e.data[31:0]); end
            end
        end
    endtask

    task automatic test_bypass();
        wr(2'b01, 5'd5, 32'h0000_0001, 5'd0, 32'h0);
        @(negedge clk);
        w_en = 2'b01; w_addr0 = 5'd5; w_data0 = 32'hCAFE_BABE; r_addr = {5'd5, 5'd0}; #1;
        n_cmp += 3;
        if (r_data_b[63:32] !== 32'hCAFE_BABE) begin n_err++; $display("FAIL bypass_fwd: got %h want cafebabe", r_data_b[63:32]); end
        if (r_data_a[63:32] !== 32'h0000_0001) begin n_err++; $display("FAIL nobypass_pre: got %h want 00000001", r_data_a[63:32]); end
        if (r_data_b[31:0] !== 32'h0) begin n_err++; $display("FAIL bypass_other_port: got %h want 0", r_data_b[31:0]); end
        @(posedge clk); #1;
        n_cmp++;
        if (r_data_a[63:32] !== 32'hCAFE_BABE) begin n_err++; $display("FAIL nobypass_post: got %h want cafebabe", r_data_a[63:32]); end
        @(negedge clk);
        model[5] = 32'hCAFE_BABE;
        w_en = 2'b01; w_addr0 = 5'd0; w_data0 = 32'hFFFF_FFFF; r_addr = {5'd0, 5'd0}; #1;
        n_cmp++;
        if (r_data_b[31:0] !== 32'h0) begin n_err++; $display("FAIL bypass_x0: got %h want 0", r_data_b[31:0]); end
        @(negedge clk);
        w_en = 2'b11; w_addr0 = 5'd9; w_data0 = 32'h90; w_addr1 = 5'd9; w_data1 = 32'h91; r_addr = {5'd9, 5'd9}; #1;
        n_cmp += 2;
        if (r_data_b[31:0] !== 32'h91) begin n_err++; $display("FAIL bypass_priority: got %h want 00000091", r_data_b[31:0]); end
        if (r_data_a[31:0] !== model[9]) begin n_err++; $display("FAIL nobypass_prio_pre: got %h want %h", r_data_a[31:0], model[9]); end
        @(negedge clk);
        w_en = 2'b00; model[9] = 32'h91; #1;
        n_cmp++;
        if (r_data_a[31:0] !== 32'h91) begin n_err++; $display("FAIL prio_commit: got %h want 00000091", r_data_a[31:0]); end
    endtask

    task automatic test_clear();
        exp_t e;
        int   cnt;
        int   dones;
        for (int i = 1; i < 32; i += 2)
            wr((i == 31) ? 2'b01 : 2'b11, 5'(i), 32'h1000_0000 + i, 5'(i + 1), 32'h1000_0000 + i + 1);
        @(negedge clk);
        clear_req = 1'b1; w_en = 2'b01; w_addr0 = 5'd2; w_data0 = 32'h2222;
        @(negedge clk);
        clear_req = 1'b0; w_en = 2'b00; model[2] = 32'h2222;
        sb.push_back('{addr: 5'd2, data: 64'h2222});
        e = sb.pop_front();
        r_addr = {e.addr, e.addr}; #1;
        n_cmp++;
        if (r_data_a[31:0] !== e.data[31:0]) begin n_err++; $display("FAIL clear_entry_write: got %h want %h", r_data_a[31:0], e.data[31:0]); end
        cnt = 0; dones = 0;
        while (busy_a && cnt < 100) begin
            cnt++;
            if (done_a) dones++;
            if (cnt == 5) begin w_en = 2'b01; w_addr0 = 5'd3; w_data0 = 32'h1234; end
            if (cnt == 6) w_en = 2'b00;
            if (cnt == 8) clear_req = 1'b1;
            if (cnt == 9) clear_req = 1'b0;
            if (cnt == 10) begin
                sb.push_back('{addr: 5'd1, data: 64'h0});
                sb.push_back('{addr: 5'd20, data: {32'h0, model[20]}});
                r_addr = {sb[1].addr, sb[0].addr}; #1;
                for (int k = 0; k < 2; k++) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (r_data_a[k*32 +: 32] !== e.data[31:0]) begin n_err++;
                        $display("FAIL clear_partial r%0d: got %h want %h", e.addr, r_data_a[k*32 +: 32], e.data[31:0]); end
                end
            end
            @(negedge clk);
        end
        n_cmp += 3;
        if (cnt != 31) begin n_err++; $display("FAIL clear_busy_len: got %0d want 31", cnt); end
        if (done_a !== 1'b1) begin n_err++; $display("FAIL clear_done_pulse: got %b want 1", done_a); end
        if (done_b !== 1'b1) begin n_err++; $display("FAIL clear_done_pulse_b: got %b want 1", done_b); end
        for (int i = 0; i < 4; i++) begin
            if (done_a) dones++;
            @(negedge clk);
        end
        n_cmp += 2;
        if (dones != 1) begin n_err++; $display("FAIL clear_done_count: got %0d want 1", dones); end
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL clear_no_restart: got %b want 0", busy_a); end
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 32; i++) sb.push_back('{addr: 5'(i), data: {32'h0, model[i]}});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); r_addr = {e.addr, e.addr}; #1;
            n_cmp += 2;
            if (r_data_a[31:0] !== e.data[31:0]) begin n_err++; $display("FAIL cleared_a r%0d: got %h want %h", e.addr, r_data_a[31:0], e.data[31:0]); end
            if (r_data_b[63:32] !== e.data[31:0]) begin n_err++; $display("FAIL cleared_b r%0d: got %h want %h", e.addr, r_data_b[63:32], e.data[31:0]); end
        end
    endtask

    task automatic test_reset_mid_clear();
        exp_t e;
        int   dones;
        int   busies;
        wr(2'b11, 5'd4, 32'h44, 5'd31, 32'h31);
        @(negedge clk); clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL async_reset_busy: got %b want 0", busy_a); end
        if (done_a !== 1'b0) begin n_err++; $display("FAIL async_reset_done: got %b want 0", done_a); end
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 32; i++) sb.push_back('{addr: 5'(i), data: {32'h0, model[i]}});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); r_addr = {e.addr, e.addr}; #1;
            n_cmp++;
            if (r_data_a[31:0] !== e.data[31:0]) begin n_err++; $display("FAIL abort_read r%0d: got %h want %h", e.addr, r_data_a[31:0], e.data[31:0]); end
        end
        @(negedge clk); rst_n = 1'b1;
        dones = 0; busies = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a) dones++;
            if (busy_a) busies++;
        end
        n_cmp += 2;
        if (dones != 0) begin n_err++; $display("FAIL abort_done_count: got %0d want 0", dones); end
        if (busies != 0) begin n_err++; $display("FAIL abort_busy_count: got %0d want 0", busies); end
    endtask

    task automatic test_param_sweep();
        exp_t e0, e1, e2;
        int   cnt;
        @(negedge clk);
        w_en_c = 2'b11; w_addr0_c = 4'd1; w_data0_c = 64'hFFFF_FFFF_0000_0001;
        w_addr1_c = 4'd2; w_data1_c = 64'hFFFF_FFFF_0000_0002;
        @(negedge clk);
        w_en_c = 2'b01; w_addr0_c = 4'd3; w_data0_c = 64'hFFFF_FFFF_0000_0003;
        @(negedge clk);
        w_en_c = 2'b00;
        sb.push_back('{addr: 5'd1, data: 64'hFFFF_FFFF_0000_0001});
        sb.push_back('{addr: 5'd2, data: 64'hFFFF_FFFF_0000_0002});
        sb.push_back('{addr: 5'd3, data: 64'hFFFF_FFFF_0000_0003});
        sb.push_back('{addr: 5'd2, data: 64'hFFFF_FFFF_0000_0002});
        sb.push_back('{addr: 5'd3, data: 64'hFFFF_FFFF_0000_0003});
        sb.push_back('{addr: 5'd1, data: 64'hFFFF_FFFF_0000_0001});
        while (sb.size() >= 3) begin
            e0 = sb.pop_front(); e1 = sb.pop_front(); e2 = sb.pop_front();
            r_addr_c = {e2.addr[3:0], e1.addr[3:0], e0.addr[3:0]}; #1;
            n_cmp += 3;
            if (r_data_c[63:0] !== e0.data) begin n_err++; $display("FAIL sweep_p0 r%0d: got %h want %h", e0.addr, r_data_c[63:0], e0.data); end
            if (r_data_c[127:64] !== e1.data) begin n_err++; $display("FAIL sweep_p1 r%0d: got %h want %h", e1.addr, r_data_c[127:64], e1.data); end
            if (r_data_c[191:128] !== e2.data) begin n_err++; $display("FAIL sweep_p2 r%0d: got %h want %h", e2.addr, r_data_c[191:128], e2.data); end
            @(negedge clk);
        end
        clear_req_c = 1'b1;
        @(negedge clk); clear_req_c = 1'b0;
        cnt = 0;
        while (busy_c && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp += 2;
        if (cnt != 15) begin n_err++; $display("FAIL sweep_busy_len: got %0d want 15", cnt); end
        if (done_c !== 1'b1) begin n_err++; $display("FAIL sweep_done: got %b want 1", done_c); end
        r_addr_c = {4'd3, 4'd2, 4'd1}; #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (r_data_c[k*64 +: 64] !== 64'h0) begin n_err++; $display("FAIL sweep_cleared p%0d: got %h want 0", k, r_data_c[k*64 +: 64]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        test_reset();
        test_write_collision();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
